// File: rtl/hline_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hline_arbiter_if : requester/engine bundle around the span arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface hline_arbiter_if #(
  parameter int CORDW = 9,
  parameter int COLRW = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CORDW-1:0] req_x0;
  logic [NREQ*CORDW-1:0] req_x1;
  logic [NREQ*CORDW-1:0] req_y;
  logic [NREQ*COLRW-1:0] req_color;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       req_done;
  logic                  eng_start;
  logic [CORDW-1:0]      eng_x0;
  logic [CORDW-1:0]      eng_x1;
  logic [CORDW-1:0]      eng_y;
  logic [COLRW-1:0]      eng_color;
  logic                  eng_done;
  logic                  busy;

  modport master (
    output req, req_x0, req_x1, req_y, req_color, eng_done,
    input  grant, req_done, eng_start, eng_x0, eng_x1, eng_y, eng_color, busy
  );

  modport slave (
    input  req, req_x0, req_x1, req_y, req_color, eng_done,
    output grant, req_done, eng_start, eng_x0, eng_x1, eng_y, eng_color, busy
  );
endinterface
`default_nettype wire

// File: rtl/hline_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hline_arbiter : round-robin sharing of one span iterator among NREQ shapers
// Rev 1.0
// ----------------------------------------------------------------------------
module hline_arbiter #(
  parameter int CORDW = 9,
  parameter int COLRW = 4,
  parameter int NREQ  = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  hline_arbiter_if.slave bus
);
  localparam int               c_IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_IDXW:0]  c_NREQ = (c_IDXW+1)'(NREQ);
  localparam logic [NREQ-1:0]  c_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_req_done;
  logic              r_eng_start;
  logic              r_busy;
  logic [CORDW-1:0]  r_x0;
  logic [CORDW-1:0]  r_x1;
  logic [CORDW-1:0]  r_y;
  logic [COLRW-1:0]  r_color;
  logic [c_IDXW-1:0] r_last;
  logic [c_IDXW-1:0] r_sel;

  logic [CORDW-1:0]  w_x0_a    [NREQ];
  logic [CORDW-1:0]  w_x1_a    [NREQ];
  logic [CORDW-1:0]  w_y_a     [NREQ];
  logic [COLRW-1:0]  w_color_a [NREQ];

  logic              w_any;
  logic [c_IDXW-1:0] w_idx;
  logic [c_IDXW:0]   w_sum;
  logic [CORDW-1:0]  w_x0;
  logic [CORDW-1:0]  w_x1;
  logic [CORDW-1:0]  w_lo;
  logic [CORDW-1:0]  w_hi;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_x0_a[gi]    = bus.req_x0[gi*CORDW +: CORDW];
    assign w_x1_a[gi]    = bus.req_x1[gi*CORDW +: CORDW];
    assign w_y_a[gi]     = bus.req_y[gi*CORDW +: CORDW];
    assign w_color_a[gi] = bus.req_color[gi*COLRW +: COLRW];
  end

  // Scan last+1, last+2, ... (mod NREQ); the first set request wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last} + (c_IDXW+1)'(k);
      if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
      if (!w_any && bus.req[w_sum[c_IDXW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_sum[c_IDXW-1:0];
      end
    end
  end

  assign w_x0 = w_x0_a[w_idx];
  assign w_x1 = w_x1_a[w_idx];
  assign w_lo = (w_x0 <= w_x1) ? w_x0 : w_x1;
  assign w_hi = (w_x0 <= w_x1) ? w_x1 : w_x0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_req_done  <= '0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y         <= '0;
      r_color     <= '0;
      r_last      <= c_IDXW'(NREQ-1);
      r_sel       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_done <= '0;
          if (w_any) begin
            r_grant     <= c_ONE << w_idx;
            r_sel       <= w_idx;
            r_busy      <= 1'b1;
            r_x0        <= w_lo;
            r_x1        <= w_hi;
            r_y         <= w_y_a[w_idx];
            r_color     <= w_color_a[w_idx];
            // Registered start so it is high during the START cycle itself.
            r_eng_start <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_eng_start <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_eng_start <= 1'b0;
          if (bus.eng_done) begin
            r_req_done <= r_grant;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_last     <= r_sel;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.req_done  = r_req_done;
  assign bus.eng_start = r_eng_start;
  assign bus.busy      = r_busy;
  assign bus.eng_x0    = r_x0;
  assign bus.eng_x1    = r_x1;
  assign bus.eng_y     = r_y;
  assign bus.eng_color = r_color;
endmodule
`default_nettype wire

// File: doc/hline_arbiter.md
Name: hline_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one horizontal-span iterator among NREQ independent requesters (e.g. triangle filler, rectangle filler, clear engine).
- Latches the winner's span and attributes, normalises the endpoints, pulses start into the iterator, and waits for its completion pulse.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the shape rasterisers and the single span iterator feeding the framebuffer write path.

Parameters:
- CORDW, 9, coordinate width in bits (x and y).
- COLRW, 4, colour index width in bits.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req  input  NREQ  per-requester span request level; held until matching req_done
- req_x0  input  NREQ*CORDW  packed x start per requester; slice i = bits [i*CORDW +: CORDW]
- req_x1  input  NREQ*CORDW  packed x end per requester
- req_y  input  NREQ*CORDW  packed row per requester
- req_color  input  NREQ*COLRW  packed colour per requester
- grant  output  NREQ  one-hot; identifies the requester currently being served
- req_done  output  NREQ  one-cycle pulse to the served requester on span completion
- eng_start  output  1  start pulse to span iterator
- eng_x0  output  CORDW  normalised left endpoint
- eng_x1  output  CORDW  normalised right endpoint
- eng_y  output  CORDW  latched row for framebuffer address
- eng_color  output  COLRW  latched colour
- eng_done  input  1  iterator completion pulse (high one cycle)
- busy  output  1  high from grant until the cycle req_done pulses

Behaviour:
- Reset (and power-up):
  - State IDLE; grant=0, req_done=0, eng_start=0, busy=0.
  - eng_x0, eng_x1, eng_y and eng_color = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- All outputs are registered. State encoding: IDLE, START, WAIT.
- IDLE:
  - req_done cleared to 0.
  - If any req bit is set, choose the first set index scanning last+1, last+2, ... modulo NREQ.
  - Register a one-hot grant, set busy=1, and latch the winner's y and colour.
  - Latch eng_x0=min(x0,x1) and eng_x1=max(x0,x1). The comparison is unsigned, full CORDW width.
  - Go to START.
- START: eng_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - eng_start=0.
  - On eng_done: req_done=grant for one cycle, grant=0, busy=0, last=index of the served requester; go to IDLE.
- Latency:
  - req sampled high in IDLE at edge N, so grant and busy are visible after edge N.
  - eng_start is high in cycle N+1.
  - req_done rises on the edge after the cycle eng_done is high.
  - Minimum gap between consecutive spans is one IDLE cycle.
- The latched span and attributes remain stable from grant until req_done. Requester inputs are ignored while not in IDLE.
- If a requester drops req mid-service, the span still completes and req_done still pulses.
- Requester obligation: deassert req in the cycle after req_done, or be re-queued. Because last advances past the served index, a lingering req cannot starve the other requesters.
- x0==x1: a single-pixel span, passed through unchanged.
- eng_done outside WAIT is ignored.
- rst mid-operation: immediate return to reset values with no req_done pulse. The span iterator shares the same rst.
- Fairness: with all NREQ requesting continuously, each is served exactly once per NREQ consecutive grants.

Test Plan:
- Single request: NREQ=4, req=0001, x0=10, x1=20, y=5, color=3. Required: grant=0001 one cycle later, eng_start a single pulse with eng_x0=10 / eng_x1=20 / eng_y=5 / eng_color=3, req_done[0] a single pulse after eng_done. Engine model asserts eng_done 12 cycles after start.
- Endpoint swap: req[2] with x0=300, x1=7. Required: eng_x0=7, eng_x1=300. Also x0=x1=42 gives eng_x0=eng_x1=42.
- Round-robin: req=1111 held high and re-asserted after each done. Required: grant order 0001, 0010, 0100, 1000, 0001, each requester's own coordinates appear on eng_* in its turn, and exactly one idle cycle between req_done and the next grant.
- Priority rotation: serve requester 1, then assert req=0011 simultaneously. Required: requester 0 is granted before requester 1 (scan starts at index 2 and wraps).
- Withdrawal and input changes: during WAIT, drop req[g] and change req_x0[g]. Required: eng_x0/eng_x1 unchanged, req_done[g] still pulses.
- Reset mid-span: assert rst for one cycle during WAIT. Required: grant, busy, eng_start and req_done all 0 next cycle, no req_done pulse, and the next arbitration starts from requester 0.
